// File: rtl/gray_ptr_sync_fifo_pkg.sv
// ----------------------------------------------------------------------------
// gray_ptr_sync_fifo_pkg
// Purpose : Shared Gray-code helpers for the Gray-pointer FIFO and its
//           pointer counters. Both functions work on a fixed 32-bit word.
//           Callers zero-extend narrower values on the way in and cast the
//           result back to their own width. Leading zeros do not change
//           either conversion, so one pair of functions serves every pointer
//           width up to 32 bits.
// Ports   : none (package)
// ----------------------------------------------------------------------------
package gray_ptr_sync_fifo_pkg;

    localparam int GRAY_MAX_W = 32;

    typedef logic [GRAY_MAX_W-1:0] gray_word_t;

    // Binary -> Gray: adjacent binary values differ in exactly one Gray bit.
    function automatic gray_word_t bin2gray(input gray_word_t b);
        return b ^ (b >> 1);
    endfunction

    // Gray -> binary: each binary bit is the XOR of all Gray bits at or above it.
    function automatic gray_word_t gray2bin(input gray_word_t g);
        gray_word_t b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage : gray_ptr_sync_fifo_pkg

// File: rtl/gray_ptr_sync_fifo_counter.sv
// ----------------------------------------------------------------------------
// gray_ptr_counter
// Purpose : Pointer register pair. It holds a binary count and a registered
//           Gray copy of that count. The Gray copy is computed from the next
//           binary value, so both registers move in the same cycle and the
//           Gray output comes straight from a flop. The count wraps modulo
//           2**W.
// Ports   : clk    in  1  rising-edge clock
//           rst    in  1  synchronous active-high reset (both registers -> 0)
//           inc_i  in  1  advance the pointer by one this cycle
//           bin_o  out W  binary pointer
//           gray_o out W  Gray pointer (registered)
// ----------------------------------------------------------------------------
module gray_ptr_counter #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    output logic [W-1:0] bin_o,
    output logic [W-1:0] gray_o
);
    import gray_ptr_sync_fifo_pkg::*;

    logic [W-1:0] bin_q, bin_d;
    logic [W-1:0] gray_q, gray_d;

    // NOTE: every signal driven in always_comb gets a default first, so no path
    //       leaves it unassigned and no latch is inferred.
    always_comb begin
        bin_d = bin_q;
        if (inc_i) begin
            bin_d = bin_q + W'(1);
        end
        gray_d = W'(bin2gray(gray_word_t'(bin_d)));
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    //       samples values from before the edge, whatever order the blocks run in.
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q  <= '0;
            gray_q <= '0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
        end
    end

    assign bin_o  = bin_q;
    assign gray_o = gray_q;

endmodule : gray_ptr_counter

// File: rtl/gray_ptr_sync_fifo.sv
// ----------------------------------------------------------------------------
// gray_ptr_sync_fifo
// Purpose : Single-clock FIFO. Each pointer is an (ADDR_W+1)-bit binary count
//           with a registered Gray copy. Full, empty, level and the threshold
//           flags depend only on registered pointer state. The Gray pointers
//           are exported so the same pointer logic can be reused across a
//           clock-domain crossing later.
// Ports   : clk           in   1         rising-edge clock
//           rst           in   1         synchronous active-high reset
//           wr_en         in   1         write request
//           wr_data       in   DATA_W    write data
//           rd_en         in   1         read request
//           rd_data       out  DATA_W    read data, registered, holds when idle
//           rd_valid      out  1         rd_data valid this cycle
//           full          out  1         level == DEPTH
//           empty         out  1         level == 0
//           almost_full   out  1         level >= AF_THRESH
//           almost_empty  out  1         level <= AE_THRESH
//           level         out  ADDR_W+1  occupancy 0..DEPTH
//           wr_ptr_gray   out  ADDR_W+1  write pointer, Gray
//           rd_ptr_gray   out  ADDR_W+1  read pointer, Gray
//           overflow      out  1         sticky: write attempted while full
//           underflow     out  1         sticky: read attempted while empty
//           clr_err       in   1         clears overflow/underflow
// ----------------------------------------------------------------------------
module gray_ptr_sync_fifo #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 6,
    parameter int AF_THRESH = 60,
    parameter int AE_THRESH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   level,
    output logic [ADDR_W:0]   wr_ptr_gray,
    output logic [ADDR_W:0]   rd_ptr_gray,
    output logic              overflow,
    output logic              underflow,
    input  logic              clr_err
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int PTR_W = ADDR_W + 1;

    localparam logic [PTR_W-1:0] AF_LVL = PTR_W'(AF_THRESH);
    localparam logic [PTR_W-1:0] AE_LVL = PTR_W'(AE_THRESH);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wr_bin, rd_bin;
    logic [PTR_W-1:0] wr_gray, rd_gray;
    logic             wr_accept, rd_accept;

    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    // Acceptance uses the full/empty flags as they stand at the start of the
    // cycle. So a full FIFO may still read, and an empty one may still write.
    // An empty FIFO never passes a word straight from write to read.
    assign wr_accept = wr_en && !full;
    assign rd_accept = rd_en && !empty;

    gray_ptr_counter #(.W(PTR_W)) u_wr_ptr (
        .clk    (clk),
        .rst    (rst),
        .inc_i  (wr_accept),
        .bin_o  (wr_bin),
        .gray_o (wr_gray)
    );

    gray_ptr_counter #(.W(PTR_W)) u_rd_ptr (
        .clk    (clk),
        .rst    (rst),
        .inc_i  (rd_accept),
        .bin_o  (rd_bin),
        .gray_o (rd_gray)
    );

    // The pointers are equal when the FIFO is empty. The FIFO is full when the
    // write pointer has lapped the read pointer by DEPTH. In Gray code that
    // shows up as the top two bits inverted and the rest equal.
    assign empty = (wr_gray == rd_gray);

    generate
        if (ADDR_W == 1) begin : g_full_w1
            assign full = (wr_gray == ~rd_gray);
        end else begin : g_full_wn
            assign full = (wr_gray == {~rd_gray[ADDR_W:ADDR_W-1], rd_gray[ADDR_W-2:0]});
        end
    endgenerate

    assign level        = wr_bin - rd_bin;
    assign almost_full  = (level >= AF_LVL);
    assign almost_empty = (level <= AE_LVL);

    // NOTE: the storage array has no reset. A reset only moves the pointers,
    //       which makes every stored word unreachable, and leaving the array
    //       unreset lets it map onto RAM.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem_q[wr_bin[ADDR_W-1:0]] <= wr_data;
        end
    end

    // Sticky error flags: a new violation wins over a clear in the same cycle.
    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (clr_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (wr_en && full) begin
            overflow_d = 1'b1;
        end
        if (rd_en && empty) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (rd_accept) begin
                rd_data_q <= mem_q[rd_bin[ADDR_W-1:0]];
            end
            rd_valid_q  <= rd_accept;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;
    assign wr_ptr_gray = wr_gray;
    assign rd_ptr_gray = rd_gray;

endmodule : gray_ptr_sync_fifo

// File: tb/tb_gray_ptr_sync_fifo.sv
// ----------------------------------------------------------------------------
// tb_gray_ptr_sync_fifo
// Purpose : Self-checking bench for gray_ptr_sync_fifo with its default
//           parameters (DATA_W=8, ADDR_W=6, AF=60, AE=4).
//           The first part is a table of single-cycle vectors with
//           hand-computed expected outputs. The second part is a set of
//           multi-cycle sequences checked against a queue-based reference
//           model plus hand-written spot checks.
// Ports   : none
// ----------------------------------------------------------------------------
module tb_gray_ptr_sync_fifo;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [6:0] level;
    logic [6:0] wr_ptr_gray;
    logic [6:0] rd_ptr_gray;
    logic       overflow;
    logic       underflow;
    logic       clr_err;

    int n_total = 0;
    int n_bad   = 0;

    gray_ptr_sync_fifo #(
        .DATA_W    (8),
        .ADDR_W    (6),
        .AF_THRESH (60),
        .AE_THRESH (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .level        (level),
        .wr_ptr_gray  (wr_ptr_gray),
        .rd_ptr_gray  (rd_ptr_gray),
        .overflow     (overflow),
        .underflow    (underflow),
        .clr_err      (clr_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------------------------------------------------------- checks
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------- reference model
    logic [7:0] m_q[$];
    logic [6:0] m_wbin = '0;
    logic [6:0] m_rbin = '0;
    logic       m_rv   = 1'b0;
    logic [7:0] m_rdd  = '0;
    logic       m_ovf  = 1'b0;
    logic       m_udf  = 1'b0;

    // Apply one cycle of inputs, advance the model at the edge, settle 1 ns after it.
    task automatic cycle(input logic r, input logic w, input logic [7:0] d,
                         input logic rd, input logic c);
        logic m_full, m_empty;
        rst = r; wr_en = w; wr_data = d; rd_en = rd; clr_err = c;
        @(posedge clk);
        m_full  = (m_q.size() == 64);
        m_empty = (m_q.size() == 0);
        if (r) begin
            m_q.delete();
            m_wbin = '0; m_rbin = '0; m_rv = 1'b0; m_rdd = '0;
            m_ovf = 1'b0; m_udf = 1'b0;
        end else begin
            m_rv = rd && !m_empty;
            if (m_rv) begin
                m_rdd = m_q.pop_front();
                m_rbin++;
            end
            if (w && !m_full) begin
                m_q.push_back(d);
                m_wbin++;
            end
            if (c) begin
                m_ovf = 1'b0;
                m_udf = 1'b0;
            end
            if (w && m_full) m_ovf = 1'b1;
            if (rd && m_empty) m_udf = 1'b1;
        end
        #1;
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
    endtask

    task automatic check_all(input string tag);
        int lvl;
        lvl = m_q.size();
        check({tag, ".level"},        level,        lvl);
        check({tag, ".empty"},        empty,        lvl == 0);
        check({tag, ".full"},         full,         lvl == 64);
        check({tag, ".almost_full"},  almost_full,  lvl >= 60);
        check({tag, ".almost_empty"}, almost_empty, lvl <= 4);
        check({tag, ".rd_valid"},     rd_valid,     m_rv);
        check({tag, ".rd_data"},      rd_data,      m_rdd);
        check({tag, ".overflow"},     overflow,     m_ovf);
        check({tag, ".underflow"},    underflow,    m_udf);
        check({tag, ".wr_ptr_gray"},  wr_ptr_gray,  m_wbin ^ (m_wbin >> 1));
        check({tag, ".rd_ptr_gray"},  rd_ptr_gray,  m_rbin ^ (m_rbin >> 1));
    endtask

    // ---------------------------------------------------------- vector table
    typedef struct {
        logic       rst, wr, rd, clr;
        logic [7:0] wdata;
        logic [6:0] lvl;
        logic       emp, ful, ae, af, rv;
        logic [7:0] rdd;
        logic       ovf, udf;
        logic [6:0] wg, rg;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic [6:0] prev_wg, prev_rg;

        rst = 1'b1; wr_en = 1'b0; wr_data = '0; rd_en = 1'b0; clr_err = 1'b0;

        //            rst wr rd clr wdata | lvl emp ful ae af rv rdd   ovf udf wg rg
        vecs[0] = '{1'b1,1'b0,1'b0,1'b0,8'h00, 7'd0,1'b1,1'b0,1'b1,1'b0,1'b0,8'h00,1'b0,1'b0,7'd0,7'd0}; // reset
        vecs[1] = '{1'b0,1'b0,1'b1,1'b0,8'h00, 7'd0,1'b1,1'b0,1'b1,1'b0,1'b0,8'h00,1'b0,1'b1,7'd0,7'd0}; // read empty
        vecs[2] = '{1'b0,1'b1,1'b0,1'b0,8'hA5, 7'd1,1'b0,1'b0,1'b1,1'b0,1'b0,8'h00,1'b0,1'b1,7'd1,7'd0}; // write A5
        vecs[3] = '{1'b0,1'b1,1'b1,1'b0,8'h3C, 7'd1,1'b0,1'b0,1'b1,1'b0,1'b1,8'hA5,1'b0,1'b1,7'd3,7'd1}; // rd+wr
        vecs[4] = '{1'b0,1'b0,1'b1,1'b1,8'h00, 7'd0,1'b1,1'b0,1'b1,1'b0,1'b1,8'h3C,1'b0,1'b0,7'd3,7'd3}; // read + clr
        vecs[5] = '{1'b0,1'b0,1'b1,1'b1,8'h00, 7'd0,1'b1,1'b0,1'b1,1'b0,1'b0,8'h3C,1'b0,1'b1,7'd3,7'd3}; // set beats clr
        vecs[6] = '{1'b0,1'b0,1'b0,1'b1,8'h00, 7'd0,1'b1,1'b0,1'b1,1'b0,1'b0,8'h3C,1'b0,1'b0,7'd3,7'd3}; // clr
        vecs[7] = '{1'b0,1'b1,1'b1,1'b0,8'h77, 7'd1,1'b0,1'b0,1'b1,1'b0,1'b0,8'h3C,1'b0,1'b1,7'd2,7'd3}; // empty rd+wr
        vecs[8] = '{1'b0,1'b0,1'b0,1'b1,8'h00, 7'd1,1'b0,1'b0,1'b1,1'b0,1'b0,8'h3C,1'b0,1'b0,7'd2,7'd3}; // clr
        vecs[9] = '{1'b0,1'b0,1'b1,1'b0,8'h00, 7'd0,1'b1,1'b0,1'b1,1'b0,1'b1,8'h77,1'b0,1'b0,7'd2,7'd2}; // read 77

        for (int i = 0; i < 10; i++) begin
            string t;
            t = $sformatf("vec%0d", i);
            rst = vecs[i].rst; wr_en = vecs[i].wr; rd_en = vecs[i].rd;
            clr_err = vecs[i].clr; wr_data = vecs[i].wdata;
            @(posedge clk);
            #1;
            check({t, ".level"},        level,        vecs[i].lvl);
            check({t, ".empty"},        empty,        vecs[i].emp);
            check({t, ".full"},         full,         vecs[i].ful);
            check({t, ".almost_empty"}, almost_empty, vecs[i].ae);
            check({t, ".almost_full"},  almost_full,  vecs[i].af);
            check({t, ".rd_valid"},     rd_valid,     vecs[i].rv);
            check({t, ".rd_data"},      rd_data,      vecs[i].rdd);
            check({t, ".overflow"},     overflow,     vecs[i].ovf);
            check({t, ".underflow"},    underflow,    vecs[i].udf);
            check({t, ".wr_ptr_gray"},  wr_ptr_gray,  vecs[i].wg);
            check({t, ".rd_ptr_gray"},  rd_ptr_gray,  vecs[i].rg);
        end

        // ---- fill to full, overflow
        cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        check_all("fill.reset");
        for (int i = 0; i < 64; i++) begin
            cycle(1'b0, 1'b1, 8'(i), 1'b0, 1'b0);
            check_all($sformatf("fill%0d", i));
        end
        check("fill.full_hand",  full,        1'b1);
        check("fill.level_hand", level,       7'd64);
        check("fill.wg_hand",    wr_ptr_gray, 7'b1100000);
        cycle(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
        check("ovf.flag",  overflow, 1'b1);
        check("ovf.level", level,    7'd64);
        check_all("ovf");
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        check_all("ovf.clr");

        // ---- drain in order, underflow
        for (int i = 0; i < 64; i++) begin
            cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
            check($sformatf("drain%0d.data_hand", i), rd_data, 8'(i));
            check_all($sformatf("drain%0d", i));
        end
        check("drain.empty_hand", empty, 1'b1);
        cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        check("udf.flag",     underflow, 1'b1);
        check("udf.rd_valid", rd_valid,  1'b0);
        check_all("udf");
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

        // ---- full with rd+wr: read wins, write rejected
        for (int i = 0; i < 64; i++) begin
            cycle(1'b0, 1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
        end
        check_all("refill");
        cycle(1'b0, 1'b1, 8'hEE, 1'b1, 1'b0);
        check("fullrw.level", level,    7'd63);
        check("fullrw.data",  rd_data,  8'h80);
        check("fullrw.ovf",   overflow, 1'b1);
        check_all("fullrw");

        // ---- steady streaming at level 10, pointers wrap
        cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        end
        check_all("stream.pre");
        prev_wg = wr_ptr_gray;
        prev_rg = rd_ptr_gray;
        for (int i = 0; i < 300; i++) begin
            cycle(1'b0, 1'b1, 8'(8'h4A + i), 1'b1, 1'b0);
            check_all($sformatf("stream%0d", i));
            check($sformatf("stream%0d.wg_onebit", i), $countones(wr_ptr_gray ^ prev_wg), 1);
            check($sformatf("stream%0d.rg_onebit", i), $countones(rd_ptr_gray ^ prev_rg), 1);
            prev_wg = wr_ptr_gray;
            prev_rg = rd_ptr_gray;
        end

        // ---- reset mid-burst at level 37
        cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 37; i++) begin
            cycle(1'b0, 1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        end
        check("rst37.level_before", level, 7'd37);
        cycle(1'b1, 1'b1, 8'hDD, 1'b0, 1'b0);
        check("rst37.empty", empty, 1'b1);
        check("rst37.level", level, 7'd0);
        check_all("rst37");
        cycle(1'b0, 1'b1, 8'h5A, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        check("rst37.newdata", rd_data, 8'h5A);
        check_all("rst37.read");
        cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        check_all("rst37.udf");
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        check("rst37.clr", underflow, 1'b0);
        check_all("rst37.clr_all");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_gray_ptr_sync_fifo
